logic_gate_pipe: RTL and testbench

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

---
 rtl/logic_gate_pkg.sv | 36 +++
 rtl/logic_gate_core.sv | 28 ++
 rtl/logic_gate_pipe.sv | 136 +++++++++++++
 tb/tb_logic_gate_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared encodings, FSM state type and reduce-fold helpers for logic_gate_pipe.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam logic MODE_BITWISE = 1'b0;
  localparam logic MODE_REDUCE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Non-inverting base operation behind each op pair, at the maximum width.
  function automatic logic [63:0] base_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
    case (op)
      OP_AND, OP_NAND: base_op = a & b;
      OP_OR,  OP_NOR:  base_op = a | b;
      OP_XOR, OP_XNOR: base_op = a ^ b;
      default:         base_op = '0;
    endcase
  endfunction

  // Identity element of the base operation, so a first beat folds to in_a.
  function automatic logic [63:0] base_ident(input logic [2:0] op);
    base_ident = (op == OP_AND || op == OP_NAND) ? '1 : '0;
  endfunction

endpackage

// File: rtl/logic_gate_core.sv
// Combinational WIDTH-bit two-operand logic op with reserved-code error flag.
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_NAND: result = ~(a & b);
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise / reduce logic-op pipeline with a single registered output stage.
// Handshakes: a beat transfers on a rising edge where valid and ready are both high.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op_sel,
  input  logic             mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic             accept, first, eff_mode;
  logic [2:0]       eff_op;
  logic [WIDTH-1:0] fold_seed, core_a, core_b, core_res;
  logic             core_err;
  logic [63:0]      ident64, seed64, a64, fold64;
  logic [CNT_W-1:0] next_cnt;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // Outside ACCUM every accepted beat starts a new transaction.
  assign first    = (state_q != ST_ACCUM);
  assign eff_op   = first ? op_sel : op_q;
  assign eff_mode = first ? mode : MODE_REDUCE;

  always_comb begin
    ident64   = base_ident(eff_op);
    fold_seed = first ? ident64[WIDTH-1:0] : acc_q;
    seed64    = '0;
    seed64[WIDTH-1:0] = fold_seed;
    a64       = '0;
    a64[WIDTH-1:0] = in_a;
    fold64    = base_op(seed64, a64, eff_op);
    core_a    = (eff_mode == MODE_BITWISE) ? in_a : fold_seed;
    core_b    = (eff_mode == MODE_BITWISE) ? in_b : in_a;
    next_cnt  = first ? CNT_W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1));
  end

  // The core also produces the final reduce result: op(acc, last a) is the inverted-as-needed fold.
  logic_gate_core #(.WIDTH(WIDTH)) u_core (
    .a      (core_a),
    .b      (core_b),
    .op     (eff_op),
    .result (core_res),
    .err    (core_err)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_count_d  = out_count_q;
    out_err_d    = out_err_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
    if (accept) begin
      if (eff_mode == MODE_BITWISE) begin
        out_valid_d  = 1'b1;
        out_result_d = core_res;
        out_count_d  = CNT_W'(1);
        out_err_d    = core_err;
        state_d      = ST_EMIT;
      end else begin
        acc_d = fold64[WIDTH-1:0];
        cnt_d = next_cnt;
        op_d  = eff_op;
        if (in_last) begin
          out_valid_d  = 1'b1;
          out_result_d = core_res;
          out_count_d  = next_cnt;
          out_err_d    = core_err;
          state_d      = ST_EMIT;
        end else begin
          state_d = ST_ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_count_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_count_q  <= out_count_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_count  = out_count_q;
  assign out_err    = out_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: directed scenarios plus randomized bursts
// checked against a beat-list reference model.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       op_sel = '0;
  logic             mode = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic [CNT_W-1:0] out_count;
  logic             out_err;
  state_e           dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [16:0] obs_q[$];
  bit mon_en = 1'b0;
  bit rand_ready_en = 1'b0;

  logic_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op_sel(op_sel), .mode(mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_count(out_count), .out_err(out_err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output transfers happen at the next rising edge; inputs only change after edges.
  always @(negedge clk)
    if (mon_en && out_valid && out_ready) obs_q.push_back({out_err, out_count, out_result});

  always @(posedge clk)
    if (rand_ready_en) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end

  // Reference: spec-level op table returning {err, result}
  function automatic logic [8:0] ref_bit(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0: ref_bit = {1'b0, a & b};
      3'd1: ref_bit = {1'b0, ~(a & b)};
      3'd2: ref_bit = {1'b0, a | b};
      3'd3: ref_bit = {1'b0, ~(a | b)};
      3'd4: ref_bit = {1'b0, a ^ b};
      3'd5: ref_bit = {1'b0, ~(a ^ b)};
      default: ref_bit = {1'b1, 8'h00};
    endcase
  endfunction

  // Reference: reduce a list of operands, returning {err, count, result}
  function automatic logic [16:0] ref_reduce(input logic [7:0] beats[$], input logic [2:0] op);
    logic [7:0] acc;
    int n;
    n = beats.size();
    acc = beats[0];
    for (int i = 1; i < n; i++) begin
      if (op <= 3'd1) acc = acc & beats[i];
      else if (op <= 3'd3) acc = acc | beats[i];
      else acc = acc ^ beats[i];
    end
    if (op[0]) acc = ~acc;
    if (n > 255) n = 255;
    if (op > 3'd5) ref_reduce = {1'b1, 8'(n), 8'h00};
    else ref_reduce = {1'b0, 8'(n), acc};
  endfunction

  // Driver: present one beat (from posedge+1) and return at posedge+1 after it transfers
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic md, input logic lst, output int waits);
    in_a = a; in_b = b; op_sel = op; mode = md; in_last = lst; in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_beat: in_ready stayed low for %0d cycles", waits);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_result, out_count, out_err} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b r=%h c=%h e=%b want all 0", out_valid, out_result, out_count, out_err);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_bitwise_vectors();
    logic [7:0] ta[10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hF0};
    logic [7:0] tb[10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C};
    logic [2:0] to[10] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0] te[10] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hCC, 8'h33};
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_beat(ta[i], tb[i], to[i], MODE_BITWISE, 1'b0, w);
      n_cmp++;
      if ({out_valid, out_result, out_count, out_err} !== {1'b1, te[i], 8'd1, 1'b0}) begin
        n_err++;
        $display("FAIL bitwise_vec%0d: got v=%b r=%h c=%0d e=%b want v=1 r=%h c=1 e=0",
                 i, out_valid, out_result, out_count, out_err, te[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reduce_basic();
    int w;
    out_ready = 1'b1;
    send_beat(8'hFF, 8'h00, 3'd0, MODE_REDUCE, 1'b0, w);
    n_cmp++;
    if (out_valid !== 1'b0 || dbg_state !== ST_ACCUM) begin
      n_err++; $display("FAIL reduce_accum: got v=%b st=%0d want v=0 st=ACCUM", out_valid, dbg_state);
    end
    send_beat(8'h0F, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0, w);
    send_beat(8'h3C, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b1, w);
    n_cmp++;
    if ({out_valid, out_result, out_count, out_err} !== {1'b1, 8'h0C, 8'd3, 1'b0}) begin
      n_err++;
      $display("FAIL reduce_and: got v=%b r=%h c=%0d e=%b want v=1 r=0c c=3 e=0", out_valid, out_result, out_count, out_err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reduce_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    send_beat(8'h01, 8'h00, 3'd3, MODE_REDUCE, 1'b0, w);
    send_beat(8'h02, 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'b0, w);
    send_beat(8'h04, 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, out_result, out_count} !== {1'b0, 1'b1, 8'hF8, 8'd3}) begin
        n_err++;
        $display("FAIL backpressure_hold%0d: got rdy=%b v=%b r=%h c=%0d want rdy=0 v=1 r=f8 c=3",
                 i, in_ready, out_valid, out_result, out_count);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL backpressure_release: in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL backpressure_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reserved();
    int w;
    out_ready = 1'b1;
    send_beat(8'h5A, 8'hC3, 3'd6, MODE_BITWISE, 1'b0, w);
    n_cmp++;
    if ({out_valid, out_result, out_err} !== {1'b1, 8'h00, 1'b1}) begin
      n_err++; $display("FAIL reserved_op: got v=%b r=%h e=%b want v=1 r=00 e=1", out_valid, out_result, out_err);
    end
    send_beat(8'hFF, 8'h0F, 3'd0, MODE_BITWISE, 1'b0, w);
    n_cmp++;
    if ({out_valid, out_result, out_err} !== {1'b1, 8'h0F, 1'b0}) begin
      n_err++; $display("FAIL reserved_clear: got v=%b r=%h e=%b want v=1 r=0f e=0", out_valid, out_result, out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    int w;
    bit seen;
    out_ready = 1'b1;
    send_beat(8'h33, 8'h00, 3'd0, MODE_REDUCE, 1'b0, w);
    send_beat(8'h77, 8'h00, 3'd0, MODE_REDUCE, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL reset_discard: output or non-IDLE state seen after reset (v=%b st=%0d)", out_valid, dbg_state); end
    send_beat(8'hA5, 8'h00, 3'd5, MODE_REDUCE, 1'b1, w);
    n_cmp++;
    if ({out_valid, out_result, out_count, out_err} !== {1'b1, 8'h5A, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL one_beat_xnor: got v=%b r=%h c=%0d e=%b want v=1 r=5a c=1 e=0", out_valid, out_result, out_count, out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w;
    logic [7:0] a, b;
    logic [2:0] op;
    logic [8:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 5));
      e = ref_bit(a, b, op);
      send_beat(a, b, op, MODE_BITWISE, 1'($urandom), w);
      n_cmp++;
      if (w !== 0 || {out_valid, out_err, out_result} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL back_to_back%0d: waits=%0d v=%b e=%b r=%h want waits=0 v=1 e=%b r=%h",
                 i, w, out_valid, out_err, out_result, e[8], e[7:0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int w;
    logic [7:0] beats[$];
    logic [16:0] e;
    out_ready = 1'b1;
    beats = {};
    for (int i = 0; i < 260; i++) beats.push_back(8'($urandom));
    for (int i = 0; i < 260; i++)
      send_beat(beats[i], 8'h00, 3'd4, MODE_REDUCE, (i == 259), w);
    e = ref_reduce(beats, 3'd4);
    n_cmp++;
    if ({out_valid, out_err, out_count, out_result} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL saturation: got v=%b e=%b c=%0d r=%h want v=1 e=%b c=%0d r=%h",
               out_valid, out_err, out_count, out_result, e[16], e[15:8], e[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int w, len;
    logic [7:0] a, b;
    logic [2:0] op;
    logic [8:0] eb;
    logic [7:0] beats[$];
    exp_q = {}; obs_q = {};
    mon_en = 1'b1;
    rand_ready_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        a = 8'($urandom); b = 8'($urandom);
        eb = ref_bit(a, b, op);
        exp_q.push_back({eb[8], 8'd1, eb[7:0]});
        send_beat(a, b, op, MODE_BITWISE, 1'($urandom), w);
      end else begin
        len = $urandom_range(1, 6);
        beats = {};
        for (int i = 0; i < len; i++) beats.push_back(8'($urandom));
        exp_q.push_back(ref_reduce(beats, op));
        send_beat(beats[0], 8'($urandom), op, MODE_REDUCE, (len == 1), w);
        for (int i = 1; i < len; i++) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          send_beat(beats[i], 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), (i == len - 1), w);
        end
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL random_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random_beat%0d: got e=%b c=%0d r=%h want e=%b c=%0d r=%h", i,
                 obs_q[i][16], obs_q[i][15:8], obs_q[i][7:0], exp_q[i][16], exp_q[i][15:8], exp_q[i][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bitwise_vectors();
    test_reduce_basic();
    test_backpressure();
    test_reserved();
    test_reset_mid_burst();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
